// File: rtl/sw_debounce.sv
// sw_debounce: per-bit switch conditioner.
// Each raw bit is passed through a 2-flop synchroniser. A new level is
// accepted only after it has been seen for STABLE_CYCLES consecutive
// cycles. Every accepted change produces a one-cycle rise or fall pulse.
// Optional feature: define SW_DEBOUNCE_TOGGLE_EN to add the sw_toggle
// output. Each accepted rising edge flips the matching sw_toggle bit.
module sw_debounce #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
`ifdef SW_DEBOUNCE_TOGGLE_EN
    output logic [WIDTH-1:0] sw_toggle,
`endif
    output logic             any_event
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    // Per-bit state is the accepted level itself. A non-zero count means
    // a change is pending.
    localparam logic [0:0] STABLE_LO = 1'b0;
    localparam logic [0:0] STABLE_HI = 1'b1;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [CW-1:0]    r_cnt     [WIDTH];
    logic [CW-1:0]    w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0] w_accept;
    logic [WIDTH-1:0] w_to_hi;
    logic [WIDTH-1:0] w_to_lo;

    // Two-flop synchroniser; nothing sits between the flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= {WIDTH{1'b0}};
            r_sync2 <= {WIDTH{1'b0}};
        end else begin
            r_sync1 <= sw_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit qualification. The count restarts whenever the input matches
    // the accepted level, so bounce earns no partial credit.
    always_comb begin
        w_accept = {WIDTH{1'b0}};
        w_to_hi  = {WIDTH{1'b0}};
        w_to_lo  = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = CNT_ZERO;
            if (r_sync2[i] == r_stable[i]) begin
                w_cnt_nxt[i] = CNT_ZERO;
            end else if (r_cnt[i] == CNT_MAX) begin
                w_accept[i]  = 1'b1;
                w_cnt_nxt[i] = CNT_ZERO;
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + {{(CW-1){1'b0}}, 1'b1};
            end
            if (w_accept[i] && (r_sync2[i] == STABLE_HI)) begin
                w_to_hi[i] = 1'b1;
            end else if (w_accept[i] && (r_sync2[i] == STABLE_LO)) begin
                w_to_lo[i] = 1'b1;
            end else begin
                w_to_hi[i] = 1'b0;
                w_to_lo[i] = 1'b0;
            end
        end
    end

    // Stability counters: one per bit. The count never goes past CNT_MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // Accepted level plus the registered one-cycle edge pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable <= {WIDTH{1'b0}};
            r_rise   <= {WIDTH{1'b0}};
            r_fall   <= {WIDTH{1'b0}};
        end else begin
            r_stable <= r_stable ^ w_accept;
            r_rise   <= w_to_hi;
            r_fall   <= w_to_lo;
        end
    end

`ifdef SW_DEBOUNCE_TOGGLE_EN
    logic [WIDTH-1:0] r_toggle;

    // Toggle flips on the same edge that registers the rise pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_toggle <= {WIDTH{1'b0}};
        end else begin
            r_toggle <= r_toggle ^ w_to_hi;
        end
    end

    assign sw_toggle = r_toggle;
`endif

    assign sw_stable = r_stable;
    assign sw_rise   = r_rise;
    assign sw_fall   = r_fall;
    assign any_event = |(r_rise | r_fall);

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: scoreboard bench for sw_debounce (WIDTH=8, STABLE_CYCLES=4).
// The reference model keeps the history of raw samples. A bit changes once
// the last STABLE_CYCLES synchronised samples all differ from the accepted
// level.
module tb_sw_debounce;

    localparam int W = 8;
    localparam int S = 4;

    typedef struct {
        logic [W-1:0] stable;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         evt;
        logic [W-1:0] tog;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_stable;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         any_event;
    logic [W-1:0] tog_obs;

    int total;
    int bad;

    exp_t         exp_q[$];
    logic [W-1:0] hist[$];
    logic [W-1:0] m_stable;
    logic [W-1:0] m_toggle;

`ifdef SW_DEBOUNCE_TOGGLE_EN
    logic [W-1:0] sw_toggle;
    assign tog_obs = sw_toggle;
`else
    assign tog_obs = '0;
`endif

    sw_debounce #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_raw    (sw_raw),
        .sw_stable (sw_stable),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
`ifdef SW_DEBOUNCE_TOGGLE_EN
        .sw_toggle (sw_toggle),
`endif
        .any_event (any_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronised value seen by the filter at edge m (1-based after reset):
    // it is the raw value sampled two edges earlier.
    function automatic logic [W-1:0] used_at(int m);
        if (m < 3) return '0;
        return hist[m-3];
    endfunction

    // Reference model: one expected record per rising edge.
    initial begin
        exp_t e;
        logic [W-1:0] smp;
        logic [W-1:0] acc;
        logic         all_diff;
        int           n;
        m_stable = '0;
        m_toggle = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                hist.delete();
                m_stable = '0;
                m_toggle = '0;
                e.stable = '0; e.rise = '0; e.fall = '0; e.evt = 1'b0; e.tog = '0;
            end else begin
                hist.push_back(sw_raw);
                n = hist.size();
                acc = '0;
                for (int i = 0; i < W; i++) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < S; k++) begin
                        smp = used_at(n - k);
                        if (smp[i] == m_stable[i]) all_diff = 1'b0;
                    end
                    acc[i] = all_diff;
                end
                e.rise   = acc & ~m_stable;
                e.fall   = acc & m_stable;
                m_stable = m_stable ^ acc;
                m_toggle = m_toggle ^ e.rise;
                e.stable = m_stable;
                e.evt    = |acc;
`ifdef SW_DEBOUNCE_TOGGLE_EN
                e.tog    = m_toggle;
`else
                e.tog    = '0;
`endif
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: pops one expectation per cycle and compares on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (sw_stable !== e.stable) begin
                    bad++;
                    $display("FAIL stable t=%0t got=%h exp=%h", $time, sw_stable, e.stable);
                end
                total++;
                if (sw_rise !== e.rise) begin
                    bad++;
                    $display("FAIL rise t=%0t got=%h exp=%h", $time, sw_rise, e.rise);
                end
                total++;
                if (sw_fall !== e.fall) begin
                    bad++;
                    $display("FAIL fall t=%0t got=%h exp=%h", $time, sw_fall, e.fall);
                end
                total++;
                if (any_event !== e.evt) begin
                    bad++;
                    $display("FAIL any_event t=%0t got=%b exp=%b", $time, any_event, e.evt);
                end
                total++;
                if (tog_obs !== e.tog) begin
                    bad++;
                    $display("FAIL toggle t=%0t got=%h exp=%h", $time, tog_obs, e.tog);
                end
            end
        end
    end

    task automatic hold(input logic [W-1:0] v, input int n);
        sw_raw = v;
        repeat (n) @(negedge clk);
    endtask

    // Stimulus: the directed scenarios first, then random levels and hold times.
    initial begin
        int n;
        logic [W-1:0] v;
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        sw_raw = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold(8'h00, 10);
        hold(8'h01, 10);
        hold(8'h00, 10);
        hold(8'h08, 1); hold(8'h00, 1); hold(8'h08, 1); hold(8'h00, 1);
        hold(8'h08, 12);
        hold(8'h00, 10);
        hold(8'hA5, 10);
        hold(8'h5A, 10);
        hold(8'h00, 10);
        // Assert reset partway through a count, then check the outputs clear at once.
        hold(8'h01, 3);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({sw_stable, sw_rise, sw_fall, any_event, tog_obs} !== '0) begin
            bad++;
            $display("FAIL async_reset got=%h/%h/%h/%b/%h exp=0", sw_stable, sw_rise, sw_fall, any_event, tog_obs);
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        hold(8'h01, 10);
        for (int p = 0; p < 3; p++) begin
            hold(8'h05, 10);
            hold(8'h01, 10);
        end
        for (int r = 0; r < 500; r++) begin
            n = $urandom_range(1, 7);
            if ($urandom_range(0, 1) == 0) begin
                v = $urandom;
            end else begin
                v = sw_raw ^ (8'h01 << $urandom_range(0, 7));
            end
            hold(v, n);
        end
        hold(sw_raw, 10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
